pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the RV32I 5-stage pipeline. It owns the write-enable and flush controls of the PC, the IF/ID register (its IFIDWrite and Flush inputs) and the ID/EX register. It resolves four hazard classes in fixed priority:
- data-memory freeze
- taken-branch redirect
- load-use stall
- instruction-fetch wait

It also keeps saturating performance counters and a data-memory timeout flag.

Parameters:
REDIRECT_BUBBLES, 1, extra cycles IF/ID flush stays asserted after a redirect (fetch latency); legal range 0-7
TIMEOUT, 255, consecutive dmem_busy cycles before err_timeout sets; legal range 1-65535
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
ifid_rs1  in  5  rs1 field of the instruction in ID
ifid_rs2  in  5  rs2 field of the instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
idex_mem_read  in  1  instruction in EX is a load
idex_rd  in  5  destination register of the instruction in EX
ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle
imem_ready  in  1  instruction memory returns valid data this cycle
dmem_busy  in  1  data memory cannot complete its access this cycle
pc_write  out  1  PC update enable
ifid_write  out  1  drives IF/ID IFIDWrite
ifid_flush  out  1  drives IF/ID Flush
idex_write  out  1  ID/EX load enable
idex_bubble  out  1  ID/EX loads a NOP (control fields zeroed)
pipe_freeze  out  1  EX/MEM and MEM/WB hold
stall_cnt  out  CNT_W  cycles with pc_write=0 outside BOOT
redirect_cnt  out  CNT_W  number of redirects accepted
err_timeout  out  1  sticky flag; dmem_busy exceeded TIMEOUT

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=BOOT; redirect counter=0, freeze counter=0, stall_cnt=0, redirect_cnt=0, err_timeout=0.
  - While reset is asserted: pc_write=0, ifid_write=0, idex_write=0, ifid_flush=1, idex_bubble=1, pipe_freeze=0.
- States: BOOT, RUN, REDIRECT, FREEZE. Outputs are combinational from state and inputs; state and counters are registered.
- BOOT:
  - Lasts exactly one cycle after reset deassertion.
  - Outputs keep their reset values.
  - Next state: RUN.
- Load-use hazard: lu = idex_mem_read & (idex_rd!=0) & ((id_use_rs1 & idex_rd==ifid_rs1) | (id_use_rs2 & idex_rd==ifid_rs2)).
- Priority in RUN and REDIRECT, first match wins:
  1. dmem_busy=1:
     - pipe_freeze=1, pc_write=0, ifid_write=0, idex_write=0, no flushes.
     - Next state: FREEZE; the current state is saved as return state.
  2. ex_branch_taken=1:
     - pc_write=1, ifid_flush=1, idex_bubble=1, idex_write=1.
     - redirect_cnt increments.
     - Next state: REDIRECT with redirect counter=REDIRECT_BUBBLES, or RUN if REDIRECT_BUBBLES=0.
  3. state=REDIRECT:
     - pc_write=imem_ready, ifid_flush=1, idex_write=1, idex_bubble=1.
     - Counter decrements only when imem_ready=1.
     - Exits to RUN in the same cycle the counter reaches 0.
  4. lu=1:
     - pc_write=0, ifid_write=0, idex_write=1, idex_bubble=1.
     - Lasts exactly one cycle; the hazard clears naturally.
  5. imem_ready=0:
     - pc_write=0, ifid_flush=1, idex_write=1; the bubble enters IF/ID.
  6. Otherwise, normal flow: pc_write=1, ifid_write=1, idex_write=1, all flush and bubble outputs 0.
- FREEZE:
  - Outputs are the same as priority 1 while dmem_busy=1.
  - The freeze counter increments, saturating at TIMEOUT.
  - err_timeout sets when the counter reaches TIMEOUT. It clears only on reset.
  - When dmem_busy=0: the freeze counter clears, and the same cycle is evaluated with the return state's rules. ex_branch_taken held during the freeze is honoured on that cycle.
  - The REDIRECT counter holds during FREEZE.
- ex_branch_taken while in REDIRECT: the counter reloads to REDIRECT_BUBBLES and redirect_cnt increments.
- Counters:
  - stall_cnt increments on every non-BOOT cycle with pc_write=0.
  - Both counters saturate at all-ones and never wrap.
- Invariants:
  - ifid_write and ifid_flush are never both 1.
  - pipe_freeze=1 implies all write enables are 0.
  - Outputs contain no X after reset.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state encoding: BOOT=2'd0, RUN=2'd1, REDIRECT=2'd2, FREEZE=2'd3
  - register-index width constant REG_W=5
  - x0 constant
- One sub-module, hazard_detect: purely combinational lu computation, reused later by the forwarding unit.
- The saturating counters are a generate loop inside the top.

Test Plan:
- Reset/boot: rst_n low 3 cycles, then high.
  - During reset: ifid_flush=1, pc_write=0.
  - Cycle 1 after release: still BOOT.
  - Cycle 2: pc_write=1, ifid_write=1.
- Load-use: idex_mem_read=1, idex_rd=5, ifid_rs1=5, id_use_rs1=1 for one cycle.
  - That cycle: pc_write=0, ifid_write=0, idex_bubble=1.
  - stall_cnt increments by 1.
  - Same case with idex_rd=0: no stall.
- Redirect, REDIRECT_BUBBLES=1: ex_branch_taken pulse.
  - ifid_flush=1 for 2 cycles, idex_bubble=1 on the first.
  - redirect_cnt=1.
  - Then normal flow.
- Freeze over branch: dmem_busy=1 for 4 cycles while ex_branch_taken=1.
  - pipe_freeze=1 for 4 cycles, all writes 0, redirect_cnt unchanged.
  - Cycle 5: redirect taken, redirect_cnt=1.
- Timeout, TIMEOUT=8: dmem_busy held 10 cycles.
  - err_timeout rises after 8 busy cycles and stays 1 after dmem_busy drops.
  - Only rst_n clears it.
- Fetch wait plus saturation:
  - imem_ready=0 for 3 cycles: ifid_flush=1, pc_write=0, stall_cnt +3.
  - With CNT_W=4, 20 stall cycles: stall_cnt holds at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control slice: controller state
// encoding, register-index width, the x0 index and the bundle of pipeline
// control outputs.
package pipe_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] X0 = '0;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2,
        FREEZE   = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_bubble;
        logic pipe_freeze;
    } ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle.
// Pipeline side (master) drives ID/EX hazard information and memory status;
// the controller (slave) drives the PC / IF/ID / ID/EX enables and flushes.
interface pipeline_hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [REG_W-1:0] ifid_rs1;
    logic [REG_W-1:0] ifid_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             idex_mem_read;
    logic [REG_W-1:0] idex_rd;
    logic             ex_branch_taken;
    logic             imem_ready;
    logic             dmem_busy;

    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_bubble;
    logic             pipe_freeze;

    modport master (
        output ifid_rs1, ifid_rs2, id_use_rs1, id_use_rs2, idex_mem_read,
               idex_rd, ex_branch_taken, imem_ready, dmem_busy,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
               pipe_freeze
    );

    modport slave (
        input  ifid_rs1, ifid_rs2, id_use_rs1, id_use_rs2, idex_mem_read,
               idex_rd, ex_branch_taken, imem_ready, dmem_busy,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
               pipe_freeze
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard detector (purely combinational).
// Ports: rs1/rs2 + use flags of the ID instruction, mem_read/rd of the EX
// instruction; lu=1 when ID needs a value the EX load has not produced yet.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic             use_rs1,
    input  logic             use_rs2,
    input  logic             mem_read,
    input  logic [REG_W-1:0] rd,
    output logic             lu
);

    // x0 is never a real producer, so a load to x0 never stalls.
    assign lu = mem_read && (rd != X0) &&
                ((use_rs1 && (rd == rs1)) || (use_rs2 && (rd == rs2)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// RV32I 5-stage hazard / sequencing controller.
// Ports: clk, rst_n (async, active low); hz (slave modport) carries hazard
// inputs and PC / IF/ID / ID/EX controls; stall_cnt and redirect_cnt are
// saturating performance counters; err_timeout is a sticky dmem timeout.
// Priority: dmem freeze > taken branch > redirect shadow > load-use >
// fetch wait > normal flow.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REDIRECT_BUBBLES = 1,
    parameter int TIMEOUT          = 255,
    parameter int CNT_W            = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    pipeline_hazard_ctrl_if.slave hz,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic             err_timeout
);

    localparam logic [2:0]  RB = 3'(REDIRECT_BUBBLES);
    localparam logic [15:0] TO = 16'(TIMEOUT);

    state_t      state, state_nx, ret_state, ret_nx, eff_state;
    logic [2:0]  rcnt, rcnt_nx;
    logic [15:0] fcnt, fcnt_nx;
    ctrl_t       c;
    logic        lu, redir_acc;
    logic [1:0]  inc;

    hazard_detect u_hd (
        .rs1      (hz.ifid_rs1),
        .rs2      (hz.ifid_rs2),
        .use_rs1  (hz.id_use_rs1),
        .use_rs2  (hz.id_use_rs2),
        .mem_read (hz.idex_mem_read),
        .rd       (hz.idex_rd),
        .lu       (lu)
    );

    // Once dmem releases, FREEZE behaves exactly like the state it interrupted.
    assign eff_state = (state == FREEZE) ? ret_state : state;

    always_comb begin
        c         = '0;
        state_nx  = state;
        ret_nx    = ret_state;
        rcnt_nx   = rcnt;
        redir_acc = 1'b0;
        if (state == BOOT) begin
            c.ifid_flush  = 1'b1;
            c.idex_bubble = 1'b1;
            state_nx      = RUN;
        end else if (hz.dmem_busy) begin
            c.pipe_freeze = 1'b1;
            state_nx      = FREEZE;
            if (state != FREEZE) ret_nx = state;
        end else begin
            state_nx = RUN;
            if (hz.ex_branch_taken) begin
                c.pc_write    = 1'b1;
                c.ifid_flush  = 1'b1;
                c.idex_write  = 1'b1;
                c.idex_bubble = 1'b1;
                redir_acc     = 1'b1;
                rcnt_nx       = RB;
                if (RB != 3'd0) state_nx = REDIRECT;
            end else if (eff_state == REDIRECT) begin
                // Wrong-path fetches are squashed until the target arrives.
                c.pc_write    = hz.imem_ready;
                c.ifid_flush  = 1'b1;
                c.idex_write  = 1'b1;
                c.idex_bubble = 1'b1;
                state_nx      = REDIRECT;
                if (hz.imem_ready) begin
                    rcnt_nx = rcnt - 3'd1;
                    if (rcnt == 3'd1) state_nx = RUN;
                end
            end else if (lu) begin
                c.idex_write  = 1'b1;
                c.idex_bubble = 1'b1;
            end else if (!hz.imem_ready) begin
                c.ifid_flush = 1'b1;
                c.idex_write = 1'b1;
            end else begin
                c.pc_write   = 1'b1;
                c.ifid_write = 1'b1;
                c.idex_write = 1'b1;
            end
        end
    end

    // Counts every frozen cycle, including the one that enters FREEZE.
    always_comb begin
        fcnt_nx = '0;
        if (hz.dmem_busy && state != BOOT)
            fcnt_nx = (fcnt == TO) ? fcnt : fcnt + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            ret_state   <= RUN;
            rcnt        <= '0;
            fcnt        <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            ret_state   <= ret_nx;
            rcnt        <= rcnt_nx;
            fcnt        <= fcnt_nx;
            err_timeout <= err_timeout | (fcnt_nx == TO);
        end
    end

    assign inc[0] = (state != BOOT) && !c.pc_write;
    assign inc[1] = redir_acc;

    for (genvar i = 0; i < 2; i++) begin : g_cnt
        logic [CNT_W-1:0] q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                 q <= '0;
            else if (inc[i] && q != '1) q <= q + 1'b1;
        end
    end

    assign stall_cnt    = g_cnt[0].q;
    assign redirect_cnt = g_cnt[1].q;

    assign hz.pc_write    = c.pc_write;
    assign hz.ifid_write  = c.ifid_write;
    assign hz.ifid_flush  = c.ifid_flush;
    assign hz.idex_write  = c.idex_write;
    assign hz.idex_bubble = c.idex_bubble;
    assign hz.pipe_freeze = c.pipe_freeze;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl (REDIRECT_BUBBLES=1, TIMEOUT=8, CNT_W=4).
// Control vector order everywhere: {pc_write, ifid_write, ifid_flush,
// idex_write, idex_bubble, pipe_freeze}.
module tb_pipeline_hazard_ctrl;

    localparam int RB   = 1;
    localparam int TO   = 8;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    localparam logic [5:0] N  = 6'b110100; // normal flow
    localparam logic [5:0] S  = 6'b000110; // load-use stall
    localparam logic [5:0] F  = 6'b001100; // fetch wait
    localparam logic [5:0] R  = 6'b101110; // redirect, target fetched
    localparam logic [5:0] RW = 6'b001110; // redirect shadow, imem not ready
    localparam logic [5:0] Z  = 6'b000001; // freeze

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] stall_cnt, redirect_cnt;
    logic          err_timeout;

    pipeline_hazard_ctrl_if hz ();

    pipeline_hazard_ctrl #(.REDIRECT_BUBBLES(RB), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hz           (hz.slave),
        .stall_cnt    (stall_cnt),
        .redirect_cnt (redirect_cnt),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       u1, u2, mr;
        logic [4:0] rd;
        logic       br, im, busy;
        logic [5:0] exp;
    } vec_t;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: a redirect shadow length, a busy run length and the
    // counters; the freeze needs no state of its own since it only masks time.
    int m_boot, m_left, m_run, m_err, m_stall, m_redir;

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(int rs1, int rs2, int u1, int u2, int mr, int rd,
                                int br, int im, int busy, logic [5:0] e);
        vec_t v;
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
        v.u1 = 1'(u1); v.u2 = 1'(u2); v.mr = 1'(mr);
        v.rd = 5'(rd); v.br = 1'(br); v.im = 1'(im); v.busy = 1'(busy);
        v.exp = e;
        return v;
    endfunction

    task automatic drive(vec_t v);
        hz.ifid_rs1 = v.rs1;        hz.ifid_rs2 = v.rs2;
        hz.id_use_rs1 = v.u1;       hz.id_use_rs2 = v.u2;
        hz.idex_mem_read = v.mr;    hz.idex_rd = v.rd;
        hz.ex_branch_taken = v.br;  hz.imem_ready = v.im;
        hz.dmem_busy = v.busy;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, N));
    endtask

    function automatic logic [5:0] model_out();
        logic lu;
        lu = hz.idex_mem_read && hz.idex_rd != 0 &&
             ((hz.id_use_rs1 && hz.idex_rd == hz.ifid_rs1) ||
              (hz.id_use_rs2 && hz.idex_rd == hz.ifid_rs2));
        if (!rst_n || m_boot != 0) return 6'b001010;
        if (hz.dmem_busy)          return Z;
        if (hz.ex_branch_taken)    return R;
        if (m_left > 0)            return hz.imem_ready ? R : RW;
        if (lu)                    return S;
        if (!hz.imem_ready)        return F;
        return N;
    endfunction

    function automatic logic [5:0] dut_out();
        return {hz.pc_write, hz.ifid_write, hz.ifid_flush,
                hz.idex_write, hz.idex_bubble, hz.pipe_freeze};
    endfunction

    // Mid-cycle: compare everything against the model.
    task automatic settle();
        @(negedge clk);
        if (!rst_n) begin
            m_boot = 1; m_left = 0; m_run = 0; m_err = 0; m_stall = 0; m_redir = 0;
        end
        chk("ctrl", int'(dut_out()), int'(model_out()));
        chk("stall_cnt", int'(stall_cnt), m_stall);
        chk("redirect_cnt", int'(redirect_cnt), m_redir);
        chk("err_timeout", int'(err_timeout), m_err);
    endtask

    // Clock edge: advance the model with the inputs held this cycle.
    task automatic edge_();
        logic [5:0] e;
        e = model_out();
        @(posedge clk);
        if (rst_n) begin
            if (m_boot != 0) m_boot = 0;
            else begin
                if (!e[5] && m_stall < MAXC) m_stall++;
                if (hz.dmem_busy) begin
                    if (m_run < 100000) m_run++;
                    if (m_run >= TO) m_err = 1;
                end else begin
                    m_run = 0;
                    if (hz.ex_branch_taken) begin
                        if (m_redir < MAXC) m_redir++;
                        m_left = RB;
                    end else if (m_left > 0 && hz.imem_ready) m_left--;
                end
            end
        end
        #1;
    endtask

    task automatic tick();
        settle();
        edge_();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();          // BOOT cycle
    endtask

    vec_t vt[20];

    initial begin
        m_boot = 1; m_left = 0; m_run = 0; m_err = 0; m_stall = 0; m_redir = 0;
        idle();

        // Reset and boot
        settle();
        chk("rst_flush", int'(hz.ifid_flush), 1);
        chk("rst_pc_write", int'(hz.pc_write), 0);
        edge_();
        tick(); tick();
        rst_n = 1'b1;
        settle();
        chk("boot_pc_write", int'(hz.pc_write), 0);
        edge_();
        settle();
        chk("run_pc_write", int'(hz.pc_write), 1);
        chk("run_ifid_write", int'(hz.ifid_write), 1);
        edge_();

        // Load-use, then the same with rd=x0
        drive(mk(5, 0, 1, 0, 1, 5, 0, 1, 0, N));
        settle();
        chk("lu_pc_write", int'(hz.pc_write), 0);
        chk("lu_ifid_write", int'(hz.ifid_write), 0);
        chk("lu_bubble", int'(hz.idex_bubble), 1);
        edge_();
        idle();
        settle();
        chk("lu_stall_cnt", int'(stall_cnt), 1);
        edge_();
        drive(mk(0, 0, 1, 0, 1, 0, 0, 1, 0, N));
        settle();
        chk("lu_x0_pc_write", int'(hz.pc_write), 1);
        edge_();
        idle();
        settle();
        chk("lu_x0_stall_cnt", int'(stall_cnt), 1);
        edge_();

        // Redirect with one extra flush cycle
        hz.ex_branch_taken = 1'b1;
        settle();
        chk("br_flush", int'(hz.ifid_flush), 1);
        chk("br_bubble", int'(hz.idex_bubble), 1);
        edge_();
        hz.ex_branch_taken = 1'b0;
        settle();
        chk("br_shadow_flush", int'(hz.ifid_flush), 1);
        chk("br_redirect_cnt", int'(redirect_cnt), 1);
        edge_();
        settle();
        chk("br_after_flush", int'(hz.ifid_flush), 0);
        chk("br_after_ifid_write", int'(hz.ifid_write), 1);
        edge_();

        // Freeze over a pending branch
        do_reset();
        hz.dmem_busy = 1'b1;
        hz.ex_branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("frz_ctrl", int'(dut_out()), int'(Z));
            chk("frz_redirect_cnt", int'(redirect_cnt), 0);
            edge_();
        end
        hz.dmem_busy = 1'b0;
        settle();
        chk("frz_release_ctrl", int'(dut_out()), int'(R));
        edge_();
        hz.ex_branch_taken = 1'b0;
        settle();
        chk("frz_redirect_cnt_after", int'(redirect_cnt), 1);
        edge_();
        tick();

        // dmem timeout, sticky until reset
        do_reset();
        hz.dmem_busy = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            settle();
            chk("timeout_err", int'(err_timeout), (i >= 9) ? 1 : 0);
            edge_();
        end
        hz.dmem_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("timeout_sticky", int'(err_timeout), 1);
            edge_();
        end
        do_reset();
        settle();
        chk("timeout_cleared", int'(err_timeout), 0);
        edge_();

        // Fetch wait and counter saturation
        hz.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("fw_ctrl", int'(dut_out()), int'(F));
            edge_();
        end
        hz.imem_ready = 1'b1;
        settle();
        chk("fw_stall_cnt", int'(stall_cnt), 3);
        edge_();
        hz.imem_ready = 1'b0;
        repeat (20) tick();
        hz.imem_ready = 1'b1;
        settle();
        chk("sat_stall_cnt", int'(stall_cnt), MAXC);
        edge_();

        // Directed priority table, applied from RUN
        vt[0]  = mk(1, 2, 1, 1, 0, 0, 0, 1, 0, N);
        vt[1]  = mk(5, 2, 1, 0, 1, 5, 0, 1, 0, S);
        vt[2]  = mk(0, 0, 1, 1, 1, 0, 0, 1, 0, N);
        vt[3]  = mk(1, 7, 0, 1, 1, 7, 0, 1, 0, S);
        vt[4]  = mk(5, 2, 0, 1, 1, 5, 0, 1, 0, N);
        vt[5]  = mk(5, 5, 1, 1, 0, 5, 0, 1, 0, N);
        vt[6]  = mk(1, 2, 0, 0, 0, 0, 0, 0, 0, F);
        vt[7]  = mk(3, 0, 1, 0, 1, 3, 0, 0, 0, S);
        vt[8]  = mk(3, 0, 1, 0, 1, 3, 1, 1, 0, R);
        vt[9]  = mk(3, 0, 1, 0, 1, 3, 0, 0, 0, RW);
        vt[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, R);
        vt[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, N);
        vt[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, Z);
        vt[13] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, Z);
        vt[14] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, R);
        vt[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, Z);
        vt[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, R);
        vt[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, N);
        vt[18] = mk(4, 0, 1, 0, 1, 4, 0, 0, 1, Z);
        vt[19] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, F);
        for (int i = 0; i < 20; i++) begin
            drive(vt[i]);
            settle();
            chk($sformatf("table[%0d]", i), int'(dut_out()), int'(vt[i].exp));
            edge_();
        end
        idle();

        // Randomized traffic against the model, with occasional resets
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 249) != 0);
            hz.ifid_rs1        = 5'($urandom_range(0, 3));
            hz.ifid_rs2        = 5'($urandom_range(0, 3));
            hz.id_use_rs1      = 1'($urandom);
            hz.id_use_rs2      = 1'($urandom);
            hz.idex_mem_read   = 1'($urandom);
            hz.idex_rd         = 5'($urandom_range(0, 3));
            hz.ex_branch_taken = ($urandom_range(0, 7) == 0);
            hz.imem_ready      = ($urandom_range(0, 4) != 0);
            hz.dmem_busy       = ($urandom_range(0, 5) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
